// File: rtl/s100_uart_pkg.sv
// Shared S-100 UART definitions: deframer state encoding, oversampling constants, default baud divider.
package s100_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // 50 MHz / 16 / 27 is within 0.5% of 115200 baud
    localparam int DEFAULT_CLK_DIV = 27;

endpackage

// File: rtl/sync_fifo.sv
// Generic show-ahead circular FIFO with occupancy count.
// Latency: a push is visible at head_dat/!empty the clk after it is accepted.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_dat,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic                  do_pop;
    logic                  do_push;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled 8N1 UART receiver into a show-ahead byte FIFO; 8E1 + parity_err with UART_RX_PARITY_EN.
// Latency: byte appears on data_out with rx_avail one clk after the stop-bit sample.
// Backpressure: none on the line; a byte arriving at a full FIFO is dropped and sets overrun.
module uart_rx_fifo
    import s100_uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic [7:0]            data_out,
    output logic                  rx_avail,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  overrun,
`ifdef UART_RX_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  framing_err
);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    logic        rx_meta;
    logic        rxs;
    logic [15:0] tick_cnt;
    logic        tick;
    rx_state_t   state;
    rx_state_t   state_nxt;
    logic [3:0]  scnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        samp_end;
    logic        mid_start;
    logic        shift_en;
    logic        push_now;
    logic        fe_set;
    logic        push_vld;
    logic        fifo_full;
    logic        fifo_empty;
    logic        ovr_set;

    // idle-high line: flops reset to 1 so reset release never looks like a start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign tick = (tick_cnt == 16'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
        end
    end

    assign samp_end  = tick && (scnt == 4'(OVERSAMPLE - 1));
    assign mid_start = tick && (scnt == 4'(MID_SAMPLE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick && !rxs) state_nxt = START;
            START:   if (mid_start)    state_nxt = rxs ? IDLE : DATA;
            DATA:    if (samp_end && bit_idx == 3'd7) state_nxt = AFTER_DATA;
            PARITY:  if (samp_end)     state_nxt = STOP;
            STOP:    if (samp_end)     state_nxt = rxs ? IDLE : BREAK;
            BREAK:   if (tick && rxs)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_en = 1'b0;
        push_now = 1'b0;
        fe_set   = 1'b0;
        if (state == DATA && samp_end) begin
            shift_en = 1'b1;
        end
        if (state == STOP && samp_end) begin
            push_now = rxs;
            fe_set   = !rxs;
        end
    end

    // every state change restarts the 16x phase so each state counts from its entry tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scnt     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            push_vld <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                scnt <= '0;
            end else if (tick) begin
                scnt <= scnt + 4'd1;
            end
            if (state_nxt == DATA && state != DATA) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shreg <= {rxs, shreg[7:1]};
            end
            push_vld <= push_now;
        end
    end

    // shreg holds still until the next DATA state, so it is stable as push data
    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push_vld),
        .push_dat (shreg),
        .pop      (rd),
        .head_dat (data_out),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fill)
    );

    assign rx_avail = !fifo_empty;
    assign ovr_set  = push_vld && fifo_full && !rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (fe_set) begin
                framing_err <= 1'b1;
            end else if (clr_err) begin
                framing_err <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic pe_set;

    // even parity: the parity bit must equal the XOR of the data bits
    assign pe_set = (state == PARITY) && samp_end && (rxs != ^shreg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err <= 1'b0;
        end else if (pe_set) begin
            parity_err <= 1'b1;
        end else if (clr_err) begin
            parity_err <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front end that sits directly upstream of the mc6850 ACIA's receive data register.
- Oversamples the raw rx pin at 16x and deframes 8N1 characters.
- Queues received bytes in a small show-ahead FIFO so the slow, ce-gated 8080 bus can drain them without losing characters at full baud.
- Reports framing and overrun conditions as sticky status bits for the ACIA status register.

Parameters:
- CLK_DIV, 27, clk cycles per 16x sample tick (50 MHz / 16 / 27 ≈ 115200 baud); legal range 1..65535.
- DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries); legal range 1..6.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx  in  1  raw serial input, idle high, asynchronous to clk
- rd  in  1  pop strobe, one clk cycle wide; ignored when FIFO empty
- clr_err  in  1  one-cycle clear of sticky error flags
- data_out  out  8  byte at FIFO head, show-ahead; valid only while rx_avail=1
- rx_avail  out  1  FIFO not empty
- fill  out  DEPTH_LOG2+1  current FIFO occupancy
- overrun  out  1  sticky: a received byte was dropped because the FIFO was full
- framing_err  out  1  sticky: a stop bit was sampled low

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low. While reset_n=0 all state clears.
  - Reset values: data_out=0, rx_avail=0, fill=0, overrun=0, framing_err=0.
  - Synchroniser flops reset to 1. Tick counter resets to 0. FSM resets to IDLE.
- Input sync: rx passes through 2 flops (rxs) before any use.
- Tick generator: free-running counter 0..CLK_DIV-1. tick=1 for one clk when the counter wraps. All FSM sampling happens on tick only.
- FSM uses a 4-bit sample counter scnt and a 3-bit bit index.
  - IDLE: on tick with rxs=0 → START, scnt=0.
  - START: count ticks. At scnt=7 (mid start bit): rxs=0 → DATA, scnt=0, bit=0; rxs=1 → IDLE (glitch rejected, nothing pushed).
  - DATA: at scnt=15, shift rxs into the shift register LSB-first and increment bit. After bit 7 → STOP, scnt=0.
  - STOP: at scnt=15, sample the stop bit.
    - rxs=1: push byte, → IDLE.
    - rxs=0: discard byte, set framing_err, → BREAK.
  - BREAK: wait for rxs=1 on a tick, then → IDLE. A held-low line yields exactly one framing error.
- FIFO: circular buffer with DEPTH_LOG2-bit read and write pointers plus a (DEPTH_LOG2+1)-bit count. Pointers wrap modulo depth.
- Push timing: a push occurs on the clk after the stop-bit tick. Byte-to-rx_avail latency is 1 clk after the stop sample; data_out is valid in the same cycle rx_avail rises.
- data_out always reflects mem[rd_ptr] combinationally from registered storage.
- Boundary cases:
  - rd while empty: no effect.
  - Push while full and no rd: byte dropped, overrun set, FIFO contents unchanged.
  - Push and rd in the same cycle: pop and push both take effect, fill unchanged. This holds when full (no overrun) and when empty (push only; rd ignored because rx_avail=0 at that edge).
  - clr_err and a new error in the same cycle: the set wins.
- reset_n asserted mid-character aborts the character silently; no partial byte is ever pushed.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Frame is 8E1. FSM gains a PARITY state between DATA and STOP, sampled at scnt=15.
  - Even parity is computed over the 8 data bits.
  - Adds output parity_err (1 bit, sticky, reset 0, cleared by clr_err).
  - A parity mismatch still pushes the byte if the stop bit is good, and sets parity_err.
- When undefined: 8N1 only; no PARITY state and no parity_err port.

Decomposition:
- Shared package s100_uart_pkg holds:
  - FSM state encoding constants: IDLE, START, DATA, PARITY, STOP, BREAK.
  - OVERSAMPLE=16 and MID_SAMPLE=7.
  - The default CLK_DIV for 50 MHz/115200.
- One natural sub-module: sync_fifo (parameterised width/depth, show-ahead, push/pop/full/empty/count), reusable later for a TX queue.
- Deframer FSM and tick generator stay in uart_rx_fifo.

Test Plan:
- Reset, then drive 0x55 at CLK_DIV=4 (64 clk/bit) → rx_avail=1 one clk after the stop sample, data_out=0x55, fill=1; rd → rx_avail=0, fill=0.
- 3 clk-tick low glitch on idle rx → START aborts to IDLE, fill stays 0, no flags set.
- Send 0xA3 with stop bit driven low, then hold rx low for 3 bit times → framing_err=1 exactly once, fill=0; pulse clr_err → framing_err=0.
- Send 9 bytes 0x01..0x09 with no rd (DEPTH_LOG2=3) → fill=8, overrun=1, head=0x01, byte 0x09 lost. Pop all 8 → sequence 0x01..0x08, then rx_avail=0.
- With FIFO full, pulse rd on exactly the push cycle of a new byte → fill stays 8, overrun stays 0, new byte is last out.
- UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong, since 0x07 has odd weight so even parity requires 1) → byte 0x07 pushed, parity_err=1; send 0x03 with parity 0 → parity_err unchanged, no new error.
